// File: rtl/lsu_axil_master.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_axil_master
//  Purpose  : AXI-lite master for the load/store unit. Accepts one core-side
//             request at a time and issues it as an AR/R read or an AW/W/B
//             write, then presents load data and error status on a response
//             handshake that is held until the core consumes it.
//  Ports    : clk, rst_n                 - clock (posedge), async active-low reset
//             req_valid/req_ready        - core request handshake
//             req_wen/addr/wdata/wstrb   - request payload (1 = store)
//             resp_valid/resp_ready      - core response handshake
//             resp_rdata/resp_err        - load data (0 for stores), bus error
//             ar*/r*/aw*/w*/b*           - AXI-lite master channels
//  Revision : 1.0  initial release
// ============================================================================
module lsu_axil_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Core request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    // Core response
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,

    // AXI-lite read address channel
    output logic [ADDR_W-1:0]     araddr,
    output logic                  arvalid,
    input  logic                  arready,

    // AXI-lite read data channel
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,

    // AXI-lite write address channel
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  awvalid,
    input  logic                  awready,

    // AXI-lite write data channel
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,

    // AXI-lite write response channel
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_WRESP = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    // Latched request payload. The load/store direction is not stored
    // separately: it is captured by the choice of RADDR vs WRITE.
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [STRB_W-1:0]     r_wstrb;

    // Per-channel completion flags for the write phase; AW and W may
    // complete in either order or together.
    logic                  r_aw_done;
    logic                  r_w_done;

    logic [DATA_W-1:0]     r_resp_rdata;
    logic                  r_resp_err;

    logic                  w_accept;
    logic                  w_ar_fire;
    logic                  w_aw_fire;
    logic                  w_w_fire;
    logic                  w_aw_ok;
    logic                  w_w_ok;

    // ------------------------------------------------------------------
    // Outputs are pure functions of state and registers, so no request
    // input ever reaches an AXI output combinationally, and an async
    // reset drops every valid/ready the moment it forces IDLE.
    // ------------------------------------------------------------------
    assign req_ready  = (r_state == S_IDLE);
    assign arvalid    = (r_state == S_RADDR);
    assign rready     = (r_state == S_RDATA);
    assign awvalid    = (r_state == S_WRITE) && !r_aw_done;
    assign wvalid     = (r_state == S_WRITE) && !r_w_done;
    assign bready     = (r_state == S_WRESP);
    assign resp_valid = (r_state == S_DONE);

    assign araddr     = r_addr;
    assign awaddr     = r_addr;
    assign wdata      = r_wdata;
    assign wstrb      = r_wstrb;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

    assign w_accept   = req_valid && req_ready;
    assign w_ar_fire  = arvalid && arready;
    assign w_aw_fire  = awvalid && awready;
    assign w_w_fire   = wvalid && wready;

    // A channel counts as done if it finished earlier or finishes now.
    assign w_aw_ok    = r_aw_done || w_aw_fire;
    assign w_w_ok     = r_w_done  || w_w_fire;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = req_wen ? S_WRITE : S_RADDR;
                end
            end
            S_RADDR: begin
                if (w_ar_fire) begin
                    w_state_next = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_WRITE: begin
                if (w_aw_ok && w_w_ok) begin
                    w_state_next = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bvalid) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request payload capture and write-channel completion tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr    <= req_addr;
                r_wdata   <= req_wdata;
                r_wstrb   <= req_wstrb;
                // Cleared on entry so each write starts with both channels open.
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_state == S_WRITE) begin
                if (w_aw_fire) begin
                    r_aw_done <= 1'b1;
                end
                if (w_w_fire) begin
                    r_w_done <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response capture. Values are held through DONE until the next
    // transaction overwrites them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            if ((r_state == S_RDATA) && rvalid) begin
                r_resp_rdata <= rdata;
                r_resp_err   <= (rresp != 2'b00);
            end else if ((r_state == S_WRESP) && bvalid) begin
                r_resp_rdata <= '0;
                r_resp_err   <= (bresp != 2'b00);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_axil_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lsu_axil_master
//  Purpose  : Self-checking bench for lsu_axil_master. The bench plays both
//             the core and an AXI-lite slave backed by a small word memory
//             that serves as the reference model for load data and stores.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_axil_master;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int BUDGET = 40;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_wen = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [DATA_W-1:0]   req_wdata = '0;
    logic [STRB_W-1:0]   req_wstrb = '0;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [DATA_W-1:0]   resp_rdata;
    logic                resp_err;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready = 1'b0;
    logic [DATA_W-1:0]   rdata = '0;
    logic [1:0]          rresp = '0;
    logic                rvalid = 1'b0;
    logic                rready;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready = 1'b0;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
    logic                wvalid;
    logic                wready = 1'b0;
    logic [1:0]          bresp = '0;
    logic                bvalid = 1'b0;
    logic                bready;

    always #5 clk = ~clk;

    lsu_axil_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready),
        .awaddr     (awaddr),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Slave memory: 16 words indexed by address bits [5:2].
    logic [31:0] mem [16];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // One complete transaction. Delays count cycles the slave withholds
    // ready/valid: for loads d_a = AR, d_r = R; for stores d_a = AW,
    // d_w = W, d_r = B. d_resp = cycles the core withholds resp_ready.
    // Entered and left just after a rising edge.
    task automatic run_txn(input logic wen, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int d_a, input int d_w, input int d_r,
                           input logic [1:0] rsp, input int d_resp);
        logic [3:0]  idx;
        logic [31:0] exp_rdata;
        logic [31:0] word;
        logic        exp_err;
        bit          got;
        bit          aw_got;
        bit          w_got;

        idx     = addr[5:2];
        exp_err = (rsp != 2'b00);
        if (wen) begin
            exp_rdata = '0;
        end else begin
            exp_rdata = mem[idx];
        end

        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = ws;
        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        // Scramble the request bus to prove the payload was latched.
        req_valid = 1'b0;
        req_wen   = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_wstrb = 4'($urandom);

        if (!wen) begin
            got = 0;
            for (int n = 0; n < BUDGET && !got; n++) begin
                arready = (n >= d_a);
                @(negedge clk);
                check("arvalid", 32'(arvalid), 32'd1);
                check("araddr", araddr, addr);
                check("req_ready_busy", 32'(req_ready), 32'd0);
                got = arvalid && arready;
                @(posedge clk); #1;
            end
            arready = 1'b0;
            check("ar_handshake", 32'(got), 32'd1);

            got = 0;
            for (int n = 0; n < BUDGET && !got; n++) begin
                rvalid = (n >= d_r);
                rdata  = rvalid ? mem[idx] : $urandom;
                rresp  = rvalid ? rsp : 2'($urandom);
                @(negedge clk);
                check("rready", 32'(rready), 32'd1);
                check("arvalid_low", 32'(arvalid), 32'd0);
                check("resp_valid_busy", 32'(resp_valid), 32'd0);
                got = rvalid && rready;
                @(posedge clk); #1;
            end
            rvalid = 1'b0;
            check("r_handshake", 32'(got), 32'd1);
        end else begin
            aw_got = 0;
            w_got  = 0;
            for (int n = 0; n < BUDGET && !(aw_got && w_got); n++) begin
                awready = (n >= d_a);
                wready  = (n >= d_w);
                @(negedge clk);
                check("awvalid", 32'(awvalid), 32'(!aw_got));
                check("wvalid", 32'(wvalid), 32'(!w_got));
                if (!aw_got) check("awaddr", awaddr, addr);
                if (!w_got) begin
                    check("wdata", wdata, wd);
                    check("wstrb", 32'(wstrb), 32'(ws));
                end
                if (awvalid && awready) aw_got = 1;
                if (wvalid && wready) w_got = 1;
                @(posedge clk); #1;
            end
            awready = 1'b0;
            wready  = 1'b0;
            check("aw_w_handshake", 32'(aw_got && w_got), 32'd1);

            got = 0;
            for (int n = 0; n < BUDGET && !got; n++) begin
                bvalid = (n >= d_r);
                bresp  = bvalid ? rsp : 2'($urandom);
                @(negedge clk);
                check("bready", 32'(bready), 32'd1);
                check("awvalid_low", 32'(awvalid), 32'd0);
                check("wvalid_low", 32'(wvalid), 32'd0);
                check("resp_valid_busy", 32'(resp_valid), 32'd0);
                got = bvalid && bready;
                @(posedge clk); #1;
            end
            bvalid = 1'b0;
            check("b_handshake", 32'(got), 32'd1);

            // Slave commits only non-error writes.
            if (rsp == 2'b00) begin
                word = mem[idx];
                for (int b = 0; b < 4; b++) begin
                    if (ws[b]) word[8*b +: 8] = wd[8*b +: 8];
                end
                mem[idx] = word;
            end
        end

        got = 0;
        for (int n = 0; n < BUDGET && !got; n++) begin
            resp_ready = (n >= d_resp);
            @(negedge clk);
            check("resp_valid", 32'(resp_valid), 32'd1);
            check("resp_rdata", resp_rdata, exp_rdata);
            check("resp_err", 32'(resp_err), 32'(exp_err));
            check("req_ready_done", 32'(req_ready), 32'd0);
            got = resp_valid && resp_ready;
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        check("resp_handshake", 32'(got), 32'd1);

        @(negedge clk);
        check("resp_valid_clr", 32'(resp_valid), 32'd0);
        check("req_ready_back", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  rsp;
        bit          wen;

        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
        check("rst_readies", {30'd0, rready, bready}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_araddr", araddr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Load, AR accepted at once, R two cycles later
        mem[4] = 32'hDEADBEEF;
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 2, 2'b00, 0);
        // Store, AW three cycles before W
        run_txn(1'b1, 32'h8000_0004, 32'h1234_5678, 4'b0011, 0, 3, 0, 2'b00, 0);
        // Store, AW and W together, SLVERR
        run_txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111, 0, 0, 0, 2'b10, 0);
        // Load, slave stalls AR for 5 cycles
        run_txn(1'b0, 32'h0000_0004, 32'h0, 4'h0, 5, 0, 0, 2'b00, 0);
        // Load, core stalls response for 4 cycles
        run_txn(1'b0, 32'h0000_0008, 32'h0, 4'h0, 0, 0, 1, 2'b00, 4);
        // W before AW, then read back a partially written word
        run_txn(1'b1, 32'h0000_0030, 32'hA1B2_C3D4, 4'b1100, 3, 1, 2, 2'b00, 1);
        run_txn(1'b0, 32'h0000_0030, 32'h0, 4'h0, 1, 0, 0, 2'b11, 0);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            wen = 1'($urandom);
            a   = {26'($urandom), 4'($urandom), 2'b00};
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(wen, a, $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), rsp, $urandom_range(0, 3));
        end

        // Reset asserted while waiting in RDATA
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 32'h0000_0014;
        @(posedge clk); #1;
        req_valid = 1'b0;
        arready   = 1'b1;
        @(posedge clk); #1;
        arready   = 1'b0;
        @(negedge clk);
        check("pre_rst_rready", 32'(rready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rready", 32'(rready), 32'd0);
        check("async_rst_valids", {29'd0, arvalid, awvalid, wvalid}, 32'd0);
        check("async_rst_bready", 32'(bready), 32'd0);
        check("async_rst_resp_valid", 32'(resp_valid), 32'd0);
        rvalid = 1'b1;
        rdata  = 32'h5555_AAAA;
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("post_rst_resp_valid", 32'(resp_valid), 32'd0);
            check("post_rst_req_ready", 32'(req_ready), 32'd1);
            check("post_rst_rready", 32'(rready), 32'd0);
        end
        @(posedge clk); #1;

        // Normal operation resumes after the abandoned transaction
        run_txn(1'b0, 32'h0000_0014, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
